sync_fifo_param: RTL

Parametrised synchronous FIFO; next generation of the team's fixed 16x4 sync FIFO. Generalised depth (any value >= 2, not only powers of two) and width. Adds simultaneous read/write in one cycle, almost-full/almost-empty thresholds, an occupancy output, a read-valid strobe, sticky overflow/underflow flags and a synchronous flush. Single clock domain; sits between a producer and a consumer in the same clock.

---
 rtl/sync_fifo_param.sv | 132 +++++++++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO (any DEPTH >= 2) with thresholds, sticky flags and flush.
// Define SYNC_FIFO_ASSERT_EN to compile the built-in SVA checks.
module sync_fifo_param #(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned DWIDTH        = 8,
    parameter int unsigned AFULL_THRESH  = DEPTH - 2,
    parameter int unsigned AEMPTY_THRESH = 2,
    localparam int unsigned AW           = $clog2(DEPTH),
    localparam int unsigned CW           = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              wr_en_i,
    input  logic [DWIDTH-1:0] din_i,
    input  logic              rd_en_i,
    output logic [DWIDTH-1:0] dout_o,
    output logic              rd_valid_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [CW-1:0]     count_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DWIDTH-1:0] dout_q, dout_d;
    logic              rd_valid_q, rd_valid_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              wr_acc, rd_acc;

    assign full_o         = (count_q == CW'(DEPTH));
    assign empty_o        = (count_q == '0);
    assign almost_full_o  = (count_q >= CW'(AFULL_THRESH));
    assign almost_empty_o = (count_q <= CW'(AEMPTY_THRESH));
    assign count_o        = count_q;
    assign dout_o         = dout_q;
    assign rd_valid_o     = rd_valid_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;

    // A flush swallows any request issued in the same cycle.
    assign wr_acc = wr_en_i && !full_o && !clr_i;
    assign rd_acc = rd_en_i && !empty_o && !clr_i;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        dout_d     = dout_q;
        rd_valid_d = 1'b0;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr_d   = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
                dout_d     = mem_q[rd_ptr_q];
                rd_valid_d = 1'b1;
            end
            if (wr_en_i && full_o) ovf_d = 1'b1;
            if (rd_en_i && empty_o) unf_d = 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dout_q     <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            dout_q     <= dout_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= din_i;
    end

`ifdef SYNC_FIFO_ASSERT_EN
    a_count_max: assert property (@(posedge clk) disable iff (!rst_n) count_q <= CW'(DEPTH))
        else $error("count exceeds DEPTH");
    a_full_dec: assert property (@(posedge clk) disable iff (!rst_n)
        full_o == (count_q == CW'(DEPTH)))
        else $error("full does not match count == DEPTH");
    a_empty_dec: assert property (@(posedge clk) disable iff (!rst_n)
        empty_o == (count_q == '0))
        else $error("empty does not match count == 0");
    a_wr_hold: assert property (@(posedge clk) disable iff (!rst_n)
        full_o && wr_en_i && !rd_en_i && !clr_i |=> $stable(wr_ptr_q))
        else $error("wr_ptr moved on a write while full");
    a_rd_hold: assert property (@(posedge clk) disable iff (!rst_n)
        empty_o && rd_en_i && !wr_en_i && !clr_i |=> $stable(rd_ptr_q))
        else $error("rd_ptr moved on a read while empty");
    a_fill: assert property (@(posedge clk) disable iff (!rst_n)
        (count_q == CW'(DEPTH - 1)) && wr_en_i && !rd_en_i && !clr_i |=> full_o)
        else $error("last write did not make the FIFO full");
    a_rd_valid: assert property (@(posedge clk) disable iff (!rst_n) rd_acc |=> rd_valid_o)
        else $error("accepted read not followed by rd_valid");
`endif

endmodule
